// File: rtl/brick_pkg.sv
// Shared types and level pattern generator for the breakout brick field.
package brick_pkg;

   localparam int unsigned HP_W_DFLT = 2;
   localparam int unsigned HP_MAX    = (1 << HP_W_DFLT) - 1;

   typedef enum logic [1:0] {
      LVL_FULL    = 2'd0,
      LVL_STAIR   = 2'd1,
      LVL_CHECKER = 2'd2,
      LVL_TOUGH   = 2'd3
   } level_e;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Hit points of one cell for a given level; rows and hp_max come from the instance.
   function automatic int unsigned pattern(input level_e level, input int unsigned row,
                                           input int unsigned col, input int unsigned rows,
                                           input int unsigned hp_max);
      int unsigned v;
      case (level)
         LVL_FULL:    v = 32'd1;
         LVL_STAIR:   v = ((rows - row) < hp_max) ? (rows - row) : hp_max;
         LVL_CHECKER: v = (((row + col) & 32'd1) == 32'd0) ? 32'd1 : 32'd0;
         LVL_TOUGH:   v = hp_max;
         default:     v = 32'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/brick_hit_unit.sv
// Decodes a hit coordinate against the field and works out the new cell HP.
module brick_hit_unit #(
   parameter int ROWS = 4,
   parameter int COLS = 10,
   parameter int HP_W = 2
) (
   input  logic [ROWS*COLS*HP_W-1:0]       i_field,
   input  logic [$clog2(ROWS)-1:0]         i_row,
   input  logic [$clog2(COLS)-1:0]         i_col,
   output logic [$clog2(ROWS*COLS)-1:0]    o_idx,
   output logic                            o_write,
   output logic                            o_destroyed,
   output logic [HP_W-1:0]                 o_new_hp
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int IDX_W = $clog2(ROWS*COLS);
   localparam logic [RW:0] ROWS_L = (RW+1)'(ROWS);
   localparam logic [CW:0] COLS_L = (CW+1)'(COLS);

   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic [HP_W-1:0]   w_cur;

   // Range check, cell select, decrement and destroy classification.
   always_comb begin
      w_idx       = '0;
      w_cur       = '0;
      o_write     = 1'b0;
      o_destroyed = 1'b0;
      o_new_hp    = '0;
      w_in_range  = ({1'b0, i_row} < ROWS_L) && ({1'b0, i_col} < COLS_L);
      if (w_in_range) begin
         w_idx = IDX_W'(i_row) * IDX_W'(COLS) + IDX_W'(i_col);
         w_cur = i_field[32'(w_idx)*HP_W +: HP_W];
      end else begin
         w_idx = '0;
      end
      if (w_in_range && (w_cur != '0)) begin
         o_write     = 1'b1;
         o_new_hp    = w_cur - HP_W'(1);
         o_destroyed = (w_cur == HP_W'(1));
      end else begin
         o_write     = 1'b0;
      end
      o_idx = w_idx;
   end

endmodule

// File: rtl/brick_field.sv
// Brick-field state manager: level loading, hit handshake, brick count and score.
module brick_field
   import brick_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int COLS   = 10,
   parameter int HP_W   = HP_W_DFLT,
   parameter int LVL_W  = 2,
   parameter int POINTS = 10
) (
   input  logic                              i_frame_clk,
   input  logic                              i_reset_n,
   input  logic                              i_reload,
   input  logic [LVL_W-1:0]                  i_level_sel,
   input  logic                              i_hit_valid,
   output logic                              o_hit_ready,
   input  logic [$clog2(ROWS)-1:0]           i_hit_row,
   input  logic [$clog2(COLS)-1:0]           i_hit_col,
   output logic                              o_ack_valid,
   output logic                              o_ack_destroyed,
   output logic [HP_W-1:0]                   o_ack_hp,
   input  logic [$clog2(ROWS)-1:0]           i_q_row,
   input  logic [$clog2(COLS)-1:0]           i_q_col,
   output logic [HP_W-1:0]                   o_q_hp,
   output logic [$clog2(ROWS*COLS+1)-1:0]    o_bricks_left,
   output logic [15:0]                       o_score,
   output logic                              o_field_clear,
   output logic                              o_clear_pulse,
   output logic                              o_busy
);

   localparam int CELLS = ROWS * COLS;
   localparam int IDX_W = $clog2(CELLS);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int BL_W  = $clog2(CELLS + 1);
   localparam int unsigned HP_TOP = (1 << HP_W) - 1;

   state_e                      r_state, w_next_state;
   logic [CELLS-1:0][HP_W-1:0]  r_hp;
   logic [IDX_W-1:0]            r_idx;
   logic [RW-1:0]               r_ld_row;
   logic [CW-1:0]               r_ld_col;
   logic [LVL_W-1:0]            r_level;
   logic [BL_W-1:0]             r_bricks_left;
   logic [15:0]                 r_score;
   logic                        r_ack_valid, r_ack_destroyed, r_clear_pulse;
   logic [HP_W-1:0]             r_ack_hp;

   logic                        w_hit_ready, w_hit_accept, w_busy, w_load_last;
   logic [HP_W-1:0]             w_load_hp;
   logic [16:0]                 w_score_sum;
   logic [IDX_W-1:0]            w_q_idx;
   logic [IDX_W-1:0]            w_hu_idx;
   logic                        w_hu_write, w_hu_destroyed;
   logic [HP_W-1:0]             w_hu_new_hp;

   brick_hit_unit #(.ROWS(ROWS), .COLS(COLS), .HP_W(HP_W)) u_hit (
      .i_field     (r_hp),
      .i_row       (i_hit_row),
      .i_col       (i_hit_col),
      .o_idx       (w_hu_idx),
      .o_write     (w_hu_write),
      .o_destroyed (w_hu_destroyed),
      .o_new_hp    (w_hu_new_hp)
   );

   assign w_load_last = (r_idx == IDX_W'(CELLS - 1));
   assign w_load_hp   = HP_W'(pattern(level_e'(r_level[1:0]), 32'(r_ld_row), 32'(r_ld_col),
                                      ROWS, HP_TOP));

   // Next state and state-decoded strobes; reload always wins over a hit.
   always_comb begin
      w_next_state = r_state;
      w_hit_ready  = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_busy = 1'b1;
            if (i_reload) begin
               w_next_state = ST_LOAD;
            end else if (w_load_last) begin
               w_next_state = ST_READY;
            end else begin
               w_next_state = ST_LOAD;
            end
         end
         ST_READY: begin
            w_hit_ready = !i_reload;
            if (i_reload) begin
               w_next_state = ST_LOAD;
            end else begin
               w_next_state = ST_READY;
            end
         end
         default: begin
            w_next_state = ST_LOAD;
            w_busy       = 1'b1;
         end
      endcase
   end

   assign w_hit_accept = i_hit_valid && w_hit_ready;

   // Saturating score add and renderer read port, blanked while loading.
   always_comb begin
      w_score_sum = {1'b0, r_score} + 17'(POINTS);
      w_q_idx     = IDX_W'(i_q_row) * IDX_W'(COLS) + IDX_W'(i_q_col);
      if ((r_state == ST_READY) && (32'(i_q_row) < ROWS) && (32'(i_q_col) < COLS)) begin
         o_q_hp = r_hp[w_q_idx];
      end else begin
         o_q_hp = '0;
      end
   end

   // State register.
   always_ff @(posedge i_frame_clk) begin
      if (!i_reset_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Field contents, load sequencer, counters and the registered hit result.
   always_ff @(posedge i_frame_clk) begin
      if (!i_reset_n) begin
         r_hp            <= '0;
         r_idx           <= '0;
         r_ld_row        <= '0;
         r_ld_col        <= '0;
         r_level         <= '0;
         r_bricks_left   <= '0;
         r_score         <= 16'h0000;
         r_ack_valid     <= 1'b0;
         r_ack_destroyed <= 1'b0;
         r_ack_hp        <= '0;
         r_clear_pulse   <= 1'b0;
      end else begin
         r_ack_valid     <= 1'b0;
         r_ack_destroyed <= 1'b0;
         r_ack_hp        <= '0;
         r_clear_pulse   <= 1'b0;
         if (i_reload) begin
            r_idx         <= '0;
            r_ld_row      <= '0;
            r_ld_col      <= '0;
            r_level       <= i_level_sel;
            r_bricks_left <= '0;
         end else if (r_state == ST_LOAD) begin
            r_hp[r_idx] <= w_load_hp;
            if (w_load_hp != '0) begin
               r_bricks_left <= r_bricks_left + BL_W'(1);
            end
            if (w_load_last) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
            if (r_ld_col == CW'(COLS - 1)) begin
               r_ld_col <= '0;
               r_ld_row <= r_ld_row + RW'(1);
            end else begin
               r_ld_col <= r_ld_col + CW'(1);
            end
         end else if (w_hit_accept) begin
            r_ack_valid     <= 1'b1;
            r_ack_destroyed <= w_hu_destroyed;
            r_ack_hp        <= w_hu_new_hp;
            if (w_hu_write) begin
               r_hp[w_hu_idx] <= w_hu_new_hp;
            end
            if (w_hu_destroyed) begin
               r_bricks_left <= r_bricks_left - BL_W'(1);
               r_score       <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
               r_clear_pulse <= (r_bricks_left == BL_W'(1));
            end
         end
      end
   end

   assign o_hit_ready     = w_hit_ready;
   assign o_busy          = w_busy;
   assign o_ack_valid     = r_ack_valid;
   assign o_ack_destroyed = r_ack_destroyed;
   assign o_ack_hp        = r_ack_hp;
   assign o_clear_pulse   = r_clear_pulse;
   assign o_bricks_left   = r_bricks_left;
   assign o_score         = r_score;
   assign o_field_clear   = (r_state == ST_READY) && (r_bricks_left == '0);

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: directed hits, reloads and resets.
module tb_brick_field;

   logic       clk;
   logic       reset_n;
   logic       reload;
   logic [1:0] level_sel;
   logic       hit_valid;
   logic       hit_ready;
   logic [1:0] hit_row;
   logic [3:0] hit_col;
   logic       ack_valid, ack_destroyed;
   logic [1:0] ack_hp;
   logic [1:0] q_row;
   logic [3:0] q_col;
   logic [1:0] q_hp;
   logic [5:0] bricks_left;
   logic [15:0] score;
   logic       field_clear, clear_pulse, busy;

   typedef struct packed {
      logic       d;
      logic [1:0] hp;
      logic       c;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;

   brick_field dut (
      .i_frame_clk     (clk),
      .i_reset_n       (reset_n),
      .i_reload        (reload),
      .i_level_sel     (level_sel),
      .i_hit_valid     (hit_valid),
      .o_hit_ready     (hit_ready),
      .i_hit_row       (hit_row),
      .i_hit_col       (hit_col),
      .o_ack_valid     (ack_valid),
      .o_ack_destroyed (ack_destroyed),
      .o_ack_hp        (ack_hp),
      .i_q_row         (q_row),
      .i_q_col         (q_col),
      .o_q_hp          (q_hp),
      .o_bricks_left   (bricks_left),
      .o_score         (score),
      .o_field_clear   (field_clear),
      .o_clear_pulse   (clear_pulse),
      .o_busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_load();
      int n;
      n = 0;
      while ((busy === 1'b1) && (n < 200)) begin
         n++;
         @(negedge clk);
      end
      check("load_cycles", n, 40);
   endtask

   task automatic do_reload(input logic [1:0] lvl, input logic with_hit);
      reload    = 1'b1;
      level_sel = lvl;
      if (with_hit) begin
         hit_valid = 1'b1;
         hit_row   = 2'd0;
         hit_col   = 4'd0;
         #1;
         check("hit_ready_during_reload", 32'(hit_ready), 32'd0);
      end
      @(negedge clk);
      reload    = 1'b0;
      hit_valid = 1'b0;
      wait_load();
   endtask

   task automatic hit(input logic [1:0] r, input logic [3:0] c,
                      input logic ed, input logic [1:0] eh, input logic ec);
      exp_t e;
      hit_row   = r;
      hit_col   = c;
      hit_valid = 1'b1;
      #1;
      check("hit_ready", 32'(hit_ready), 32'd1);
      e.d = ed;
      e.hp = eh;
      e.c = ec;
      exp_q.push_back(e);
      @(negedge clk);
      hit_valid = 1'b0;
   endtask

   task automatic query(input logic [1:0] r, input logic [3:0] c, input logic [1:0] exp);
      q_row = r;
      q_col = c;
      #1;
      check("q_hp", 32'(q_hp), 32'(exp));
   endtask

   initial begin
      int k;
      total     = 0;
      bad       = 0;
      reset_n   = 1'b0;
      reload    = 1'b0;
      level_sel = 2'd0;
      hit_valid = 1'b0;
      hit_row   = 2'd0;
      hit_col   = 4'd0;
      q_row     = 2'd0;
      q_col     = 4'd0;

      // Monitor: every ack must match the oldest expected response.
      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (ack_valid === 1'b1) begin
               if (busy === 1'b1) begin
                  total++;
                  bad++;
                  $display("FAIL ack_in_load: ack_valid=1 while busy at %0t", $time);
               end
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_ack: got ack, expected none at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_destroyed", 32'(ack_destroyed), 32'(e.d));
                  check("ack_hp", 32'(ack_hp), 32'(e.hp));
                  check("ack_clear_pulse", 32'(clear_pulse), 32'(e.c));
               end
            end else if (clear_pulse === 1'b1) begin
               total++;
               bad++;
               $display("FAIL stray_clear_pulse: clear_pulse=1 without ack at %0t", $time);
            end
         end
      join_none

      // Reset, then level 0 load.
      @(negedge clk);
      reset_n = 1'b1;
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_bricks", 32'(bricks_left), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_ack_valid", 32'(ack_valid), 32'd0);
      check("rst_clear_pulse", 32'(clear_pulse), 32'd0);
      query(2'd0, 4'd0, 2'd0);
      wait_load();
      check("lvl0_bricks", 32'(bricks_left), 32'd40);
      check("lvl0_score", 32'(score), 32'd0);
      check("lvl0_field_clear", 32'(field_clear), 32'd0);
      query(2'd3, 4'd9, 2'd1);

      // Destroy (1,2), then hit the empty cell.
      hit(2'd1, 4'd2, 1'b1, 2'd0, 1'b0);
      check("hit1_bricks", 32'(bricks_left), 32'd39);
      check("hit1_score", 32'(score), 32'd10);
      query(2'd1, 4'd2, 2'd0);
      hit(2'd1, 4'd2, 1'b0, 2'd0, 1'b0);
      check("hit2_bricks", 32'(bricks_left), 32'd39);
      check("hit2_score", 32'(score), 32'd10);

      // TOUGH level: three back-to-back hits on one cell.
      do_reload(2'd3, 1'b0);
      check("tough_bricks", 32'(bricks_left), 32'd40);
      check("tough_score_kept", 32'(score), 32'd10);
      query(2'd0, 4'd0, 2'd3);
      hit(2'd0, 4'd0, 1'b0, 2'd2, 1'b0);
      hit(2'd0, 4'd0, 1'b0, 2'd1, 1'b0);
      hit(2'd0, 4'd0, 1'b1, 2'd0, 1'b0);
      check("tough_bricks_after", 32'(bricks_left), 32'd39);
      check("tough_score", 32'(score), 32'd20);

      // CHECKER level: clear all 20 lit cells.
      do_reload(2'd2, 1'b0);
      check("checker_bricks", 32'(bricks_left), 32'd20);
      query(2'd0, 4'd1, 2'd0);
      query(2'd1, 4'd1, 2'd1);
      k = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 10; c++) begin
            if (((r + c) % 2) == 0) begin
               k++;
               if (k == 20) begin
                  check("field_clear_before_last", 32'(field_clear), 32'd0);
               end
               hit(2'(r), 4'(c), 1'b1, 2'd0, (k == 20));
            end
         end
      end
      check("checker_bricks_zero", 32'(bricks_left), 32'd0);
      check("checker_field_clear", 32'(field_clear), 32'd1);
      check("checker_score", 32'(score), 32'd220);
      hit(2'd0, 4'd1, 1'b0, 2'd0, 1'b0);
      check("field_clear_held", 32'(field_clear), 32'd1);

      // Reload with a simultaneous hit: the hit must be refused.
      do_reload(2'd0, 1'b1);
      check("coll_bricks", 32'(bricks_left), 32'd40);
      check("coll_field_clear", 32'(field_clear), 32'd0);
      query(2'd0, 4'd0, 2'd1);

      // Out-of-range column.
      hit(2'd0, 4'd12, 1'b0, 2'd0, 1'b0);
      check("oor_bricks", 32'(bricks_left), 32'd40);
      check("oor_score", 32'(score), 32'd220);
      query(2'd0, 4'd15, 2'd0);

      // Reset in the middle of a STAIR load.
      reload    = 1'b1;
      level_sel = 2'd1;
      @(negedge clk);
      reload = 1'b0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
      end
      check("stair_partial_bricks", 32'(bricks_left), 32'd17);
      check("stair_busy", 32'(busy), 32'd1);
      query(2'd0, 4'd0, 2'd0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("midload_rst_bricks", 32'(bricks_left), 32'd0);
      check("midload_rst_score", 32'(score), 32'd0);
      wait_load();
      check("midload_reload_bricks", 32'(bricks_left), 32'd40);
      query(2'd0, 4'd0, 2'd1);

      // Reset together with a hit: no ack may appear.
      hit_row   = 2'd2;
      hit_col   = 4'd3;
      hit_valid = 1'b1;
      reset_n   = 1'b0;
      @(negedge clk);
      hit_valid = 1'b0;
      reset_n   = 1'b1;
      check("midhit_ack_valid", 32'(ack_valid), 32'd0);
      check("midhit_busy", 32'(busy), 32'd1);
      wait_load();
      check("midhit_bricks", 32'(bricks_left), 32'd40);
      @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
